// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation (p^a / p^b): 12, 8 or 6 rounds, UNROLL rounds per clock.
// The 320-bit state is held as five 64-bit words; word x0 occupies bits 319:256, x4 bits 63:0.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start_i; state_o holds the last result
//   RUN   | applying UNROLL rounds per edge until absolute round 11 is done
module ascon_permutation_iter #(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [1:0]   rounds_sel_i,
  input  logic [319:0] state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [319:0] state_o
);

  typedef logic [0:4][63:0] type_state;
  typedef enum logic {ST_IDLE, ST_RUN} fsm_t;

  if (UNROLL != 1 && UNROLL != 2) begin : g_unroll_check
    $error("ascon_permutation_iter: UNROLL must be 1 or 2");
  end

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One full round: constant addition, bit-sliced S-box, linear diffusion.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    type_state   r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];
    x2[7:0] = x2[7:0] ^ {4'hF - idx, idx};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    r[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    r[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    r[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    r[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return r;
  endfunction

  fsm_t      st_q, st_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] first_rnd;
  logic       done_q, done_d;
  type_state  state_q, state_d, round_out;

  assign busy_o  = (st_q == ST_RUN);
  assign done_o  = done_q;
  assign state_o = state_q;

  // Starting absolute round index for the selected round count; reserved code runs 12.
  always_comb begin
    first_rnd = 4'd0;
    case (rounds_sel_i)
      2'b01:   first_rnd = 4'd4;
      2'b10:   first_rnd = 4'd6;
      default: first_rnd = 4'd0;
    endcase
  end

  // Chain of UNROLL rounds starting at the current round index.
  always_comb begin
    round_out = state_q;
    for (int k = 0; k < UNROLL; k++) begin
      round_out = ascon_round(round_out, rnd_q + 4'(k));
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, pulse done on the final edge.
  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    done_d  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = state_i;
          rnd_d   = first_rnd;
          st_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        if (rnd_q + 4'(UNROLL) == 4'd12) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'(UNROLL);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset overrides any start request.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q    <= ST_IDLE;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Randomized bench for ascon_permutation_iter against a table-driven ASCON model.
module tb_ascon_permutation_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0, start2 = 1'b0;
  logic [1:0]   sel1 = 2'b00, sel2 = 2'b00;
  logic [319:0] st_in1 = '0, st_in2 = '0;
  logic         busy1, busy2, done1, done2;
  logic [319:0] st_out1, st_out2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0] sbox_tab [32];

  always #5 clk = ~clk;

  ascon_permutation_iter #(.UNROLL(1)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .rounds_sel_i(sel1),
    .state_i(st_in1), .busy_o(busy1), .done_o(done1), .state_o(st_out1)
  );

  ascon_permutation_iter #(.UNROLL(2)) dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start2), .rounds_sel_i(sel2),
    .state_i(st_in2), .busy_o(busy2), .done_o(done2), .state_o(st_out2)
  );

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference round: S-box applied as a 32-entry lookup per bit column (x0 = MSB).
  function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    int r1 [5] = '{19, 61, 1, 10, 7};
    int r2 [5] = '{28, 39, 6, 17, 41};
    logic [319:0] res;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'((15 - i) * 16 + i);
    for (int b = 0; b < 64; b++) begin
      v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = sbox_tab[v];
      for (int k = 0; k < 5; k++) y[k][b] = o[4 - k];
    end
    for (int k = 0; k < 5; k++) res[319 - 64*k -: 64] = y[k] ^ rot(y[k], r1[k]) ^ rot(y[k], r2[k]);
    return res;
  endfunction

  function automatic int nr_of(input logic [1:0] sel);
    return (sel == 2'b01) ? 8 : (sel == 2'b10) ? 6 : 12;
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int nr);
    logic [319:0] r = s;
    for (int i = 12 - nr; i < 12; i++) r = model_round(r, i);
    return r;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Runs one permutation on the chosen instance; returns result, edges to done and busy cycles.
  task automatic op(input int which, input logic [1:0] sel, input logic [319:0] st,
                    output logic [319:0] res, output int edges, output int busy_cnt);
    logic done_seen = 1'b0;
    @(negedge clk);
    if (which == 2) begin start2 = 1'b1; sel2 = sel; st_in2 = st; end
    else begin start1 = 1'b1; sel1 = sel; st_in1 = st; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    busy_cnt = (which == 2) ? int'(busy2) : int'(busy1);
    edges = 0;
    while (!done_seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if ((which == 2) ? done2 : done1) done_seen = 1'b1;
      else busy_cnt += (which == 2) ? int'(busy2) : int'(busy1);
    end
    chk("done_seen", 320'(done_seen), 320'(1));
    res = (which == 2) ? st_out2 : st_out1;
    chk("busy_at_done", 320'((which == 2) ? busy2 : busy1), 320'(0));
    @(negedge clk);
    chk("done_one_cycle", 320'((which == 2) ? done2 : done1), 320'(0));
    chk("idle_stable", (which == 2) ? st_out2 : st_out1, res);
  endtask

  initial begin
    logic [319:0] t1, a, b, c, res, zero_res;
    logic [1:0]   sel;
    int edges, busy_cnt;
    logic done_seen;
    int n;

    sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 320'(busy1), 320'(0));
    chk("rst_done", 320'(done1), 320'(0));
    chk("rst_state", st_out1, '0);
    rst = 1'b0;

    // Single round 6 from a fixed state
    t1 = {64'h8859263f4c5d6e8f, 64'h00c18e8584858607, 64'h7f7f7f7f7f7f7f8f,
          64'h80c0848680808070, 64'h8888888a88888888};
    start1 = 1'b1; sel1 = 2'b10; st_in1 = t1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("load_state", st_out1, t1);
    chk("load_busy", 320'(busy1), 320'(1));
    @(posedge clk);
    @(negedge clk);
    chk("round6", st_out1, model_round(t1, 6));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full p^a on the zero state
    op(1, 2'b00, '0, zero_res, edges, busy_cnt);
    chk("pa_zero_lat", 320'(edges), 320'(12));
    chk("pa_zero_busy", 320'(busy_cnt), 320'(12));
    chk("pa_zero_res", zero_res, model_perm('0, 12));

    // Every round selection, then random ones
    for (int k = 0; k < 12; k++) begin
      sel = (k < 4) ? 2'(k) : 2'($urandom_range(0, 3));
      a = rand320();
      op(1, sel, a, res, edges, busy_cnt);
      n = nr_of(sel);
      chk($sformatf("lat_sel%0d", sel), 320'(edges), 320'(n));
      chk($sformatf("busy_sel%0d", sel), 320'(busy_cnt), 320'(n));
      chk($sformatf("res_sel%0d", sel), res, model_perm(a, n));
    end

    // Start held through RUN with changing inputs, then back-to-back accept on done
    a = rand320(); b = rand320(); c = rand320();
    @(negedge clk);
    start1 = 1'b1; sel1 = 2'b00; st_in1 = a;
    @(posedge clk);
    @(negedge clk);
    st_in1 = b; sel1 = 2'b10;
    edges = 0; done_seen = 1'b0;
    while (!done_seen && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
      if (done1) done_seen = 1'b1;
    end
    chk("hold_done_seen", 320'(done_seen), 320'(1));
    chk("hold_lat", 320'(edges), 320'(12));
    chk("hold_res", st_out1, model_perm(a, 12));
    st_in1 = c; sel1 = 2'b00;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_busy", 320'(busy1), 320'(1));
    edges = 1; done_seen = 1'b0;
    while (!done_seen && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
      if (done1) done_seen = 1'b1;
    end
    chk("b2b_done_seen", 320'(done_seen), 320'(1));
    chk("b2b_gap", 320'(edges), 320'(13));
    chk("b2b_res", st_out1, model_perm(c, 12));

    // Reset during the 5th RUN cycle, with start also asserted
    @(negedge clk);
    start1 = 1'b1; sel1 = 2'b00; st_in1 = rand320();
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 320'(busy1), 320'(1));
    rst = 1'b1; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 320'(busy1), 320'(0));
    chk("midrst_done", 320'(done1), 320'(0));
    chk("midrst_state", st_out1, '0);
    rst = 1'b0; start1 = 1'b0;
    a = rand320();
    op(1, 2'b01, a, res, edges, busy_cnt);
    chk("post_rst_lat", 320'(edges), 320'(8));
    chk("post_rst_res", res, model_perm(a, 8));

    // Two rounds per clock
    op(2, 2'b00, '0, res, edges, busy_cnt);
    chk("u2_zero_lat", 320'(edges), 320'(6));
    chk("u2_zero_busy", 320'(busy_cnt), 320'(6));
    chk("u2_zero_res", res, model_perm('0, 12));
    chk("u2_vs_u1", res, zero_res);
    for (int k = 0; k < 6; k++) begin
      sel = (k < 4) ? 2'(k) : 2'($urandom_range(0, 3));
      a = rand320();
      op(2, sel, a, res, edges, busy_cnt);
      n = nr_of(sel);
      chk($sformatf("u2_lat_sel%0d", sel), 320'(edges), 320'(n / 2));
      chk($sformatf("u2_res_sel%0d", sel), res, model_perm(a, n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
